wb_motores: RTL and testbench

- Wishbone B3 classic slave that drives up to NUM_MOT DC-motor H-bridges (Rubik's-cube face motors) with per-channel PWM and direction control.
- Sits on the LM32 system bus. Software writes a shared PWM period, a per-motor enable mask and a per-motor mode/duty word.
- Produces registered H-bridge input pairs (mot_a_o / mot_b_o).

---
 rtl/wb_motores.sv | 152 +++++++++++++++
 tb/tb_wb_motores.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_motores.sv
// Wishbone B3 classic slave driving NUM_MOT H-bridge pairs with per-channel PWM and direction.
// Optional auto-stop run counter enabled by defining WB_MOTORES_TIMEOUT_EN.
module wb_motores #(
    parameter int NUM_MOT    = 6,
    parameter int DEF_PERIOD = 1000,
    parameter int CNT_W      = 20
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [31:0]        wb_adr_i,
    input  logic [31:0]        wb_dat_i,
    output logic [31:0]        wb_dat_o,
    input  logic               wb_we_i,
    input  logic               wb_cyc_i,
    input  logic               wb_stb_i,
    input  logic [3:0]         wb_sel_i,
    output logic               wb_ack_o,
    output logic [NUM_MOT-1:0] mot_a_o,
    output logic [NUM_MOT-1:0] mot_b_o
);
    localparam int CMP_W = (CNT_W > 16) ? CNT_W : 16;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [1:0] MODE_STOP  = 2'b00;
    localparam logic [1:0] MODE_FWD   = 2'b01;
    localparam logic [1:0] MODE_REV   = 2'b10;
    localparam logic [1:0] MODE_BRAKE = 2'b11;

    logic [CNT_W-1:0]   period_q, period_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [NUM_MOT-1:0] enable_q, enable_d;
    logic [1:0]         mode_q [NUM_MOT];
    logic [1:0]         mode_d [NUM_MOT];
    logic [15:0]        duty_q [NUM_MOT];
    logic [15:0]        duty_d [NUM_MOT];
    logic [7:0]         runcnt_q [NUM_MOT];
    logic [7:0]         runcnt_d [NUM_MOT];
    logic               ack_q;
    logic [31:0]        dat_q, dat_d, rd_data;
    logic [NUM_MOT-1:0] mot_a_q, mot_a_d, mot_b_q, mot_b_d;

    logic       access, wr, rd, wrap, pwm;
    logic [5:0] idx;
    logic       unused_bits;

    assign access = wb_cyc_i & wb_stb_i & ~ack_q;
    assign wr     = access & wb_we_i;
    assign rd     = access & ~wb_we_i;
    assign idx    = wb_adr_i[7:2];
    assign wrap   = (period_q != '0) && (cnt_q == period_q - CNT_ONE);

    assign unused_bits = &{1'b0, wb_sel_i, wb_adr_i[31:8], wb_adr_i[1:0], wb_dat_i};

    always_comb begin
        rd_data = '0;
        if (idx == 6'd0) begin
            rd_data = 32'(period_q);
        end else if (idx == 6'd1) begin
            rd_data = 32'(enable_q);
        end else begin
            for (int n = 0; n < NUM_MOT; n++) begin
                if (idx == 6'(n + 2)) begin
                    rd_data = {duty_q[n], runcnt_q[n], 6'b0, mode_q[n]};
                end
            end
        end
    end

    always_comb begin
        period_d = period_q;
        enable_d = enable_q;
        dat_d    = dat_q;
        cnt_d    = cnt_q + CNT_ONE;
        mot_a_d  = '0;
        mot_b_d  = '0;
        pwm      = 1'b0;

        if (wr && idx == 6'd0) period_d = wb_dat_i[CNT_W-1:0];
        if (wr && idx == 6'd1) enable_d = wb_dat_i[NUM_MOT-1:0];
        if (rd) dat_d = rd_data;

        // A PERIOD write restarts the PWM cycle from zero.
        if (period_q == '0 || wrap || (wr && idx == 6'd0)) cnt_d = '0;

        for (int n = 0; n < NUM_MOT; n++) begin
            mode_d[n]   = mode_q[n];
            duty_d[n]   = duty_q[n];
            runcnt_d[n] = runcnt_q[n];
`ifdef WB_MOTORES_TIMEOUT_EN
            if (wrap && runcnt_q[n] != 8'd0 &&
                (mode_q[n] == MODE_FWD || mode_q[n] == MODE_REV)) begin
                runcnt_d[n] = runcnt_q[n] - 8'd1;
                if (runcnt_q[n] == 8'd1) mode_d[n] = MODE_STOP;
            end
`endif
            // Bus write placed after the decrement so it takes priority.
            if (wr && idx == 6'(n + 2)) begin
                mode_d[n] = wb_dat_i[1:0];
                duty_d[n] = wb_dat_i[31:16];
`ifdef WB_MOTORES_TIMEOUT_EN
                runcnt_d[n] = wb_dat_i[15:8];
`endif
            end

            pwm = enable_q[n] && (period_q != '0) &&
                  (CMP_W'(cnt_q) < CMP_W'(duty_q[n]));
            case (mode_q[n])
                MODE_FWD:   mot_a_d[n] = pwm;
                MODE_REV:   mot_b_d[n] = pwm;
                MODE_BRAKE: begin
                    mot_a_d[n] = 1'b1;
                    mot_b_d[n] = 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            period_q <= CNT_W'(DEF_PERIOD);
            cnt_q    <= '0;
            enable_q <= '0;
            ack_q    <= 1'b0;
            dat_q    <= '0;
            mot_a_q  <= '0;
            mot_b_q  <= '0;
            for (int n = 0; n < NUM_MOT; n++) begin
                mode_q[n]   <= '0;
                duty_q[n]   <= '0;
                runcnt_q[n] <= '0;
            end
        end else begin
            period_q <= period_d;
            cnt_q    <= cnt_d;
            enable_q <= enable_d;
            ack_q    <= access;
            dat_q    <= dat_d;
            mot_a_q  <= mot_a_d;
            mot_b_q  <= mot_b_d;
            for (int n = 0; n < NUM_MOT; n++) begin
                mode_q[n]   <= mode_d[n];
                duty_q[n]   <= duty_d[n];
                runcnt_q[n] <= runcnt_d[n];
            end
        end
    end

    assign wb_ack_o = ack_q;
    assign wb_dat_o = dat_q;
    assign mot_a_o  = mot_a_q;
    assign mot_b_o  = mot_b_q;
endmodule

// File: tb/tb_wb_motores.sv
// Self-checking bench for wb_motores: register model plus per-period duty counting of H-bridge outputs.
module tb_wb_motores;
  localparam int NUM = 6;
`ifdef WB_MOTORES_TIMEOUT_EN
  localparam logic [31:0] MOT_MASK = 32'hFFFF_FF03;
`else
  localparam logic [31:0] MOT_MASK = 32'hFFFF_0003;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [31:0]    wb_adr, wb_dat_w, wb_dat_r;
  logic           wb_we, wb_cyc, wb_stb, wb_ack;
  logic [3:0]     wb_sel;
  logic [NUM-1:0] mot_a, mot_b;

  wb_motores #(.NUM_MOT(NUM), .DEF_PERIOD(1000), .CNT_W(20)) dut (
    .clk(clk), .rst(rst),
    .wb_adr_i(wb_adr), .wb_dat_i(wb_dat_w), .wb_dat_o(wb_dat_r),
    .wb_we_i(wb_we), .wb_cyc_i(wb_cyc), .wb_stb_i(wb_stb), .wb_sel_i(wb_sel),
    .wb_ack_o(wb_ack), .mot_a_o(mot_a), .mot_b_o(mot_b)
  );

  int tests = 0;
  int fails = 0;

  // ---------------- reference model ----------------
  logic [31:0] m_period;
  logic [31:0] m_enable;
  logic [31:0] m_mot [NUM];
  int ca [NUM];
  int cb [NUM];
  int cab;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    tests++;
    assert (obs === want) else begin
      fails++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, want);
    end
  endtask

  task automatic model_write(input logic [31:0] a, input logic [31:0] d);
    int i;
    i = int'(a[7:2]);
    if (i == 0) m_period = d & 32'h000F_FFFF;
    else if (i == 1) m_enable = d & ((32'd1 << NUM) - 32'd1);
    else if (i >= 2 && i < 2 + NUM) m_mot[i-2] = d & MOT_MASK;
  endtask

  function automatic logic [31:0] model_read(input logic [31:0] a);
    int i;
    i = int'(a[7:2]);
    if (i == 0) return m_period;
    if (i == 1) return m_enable;
    if (i >= 2 && i < 2 + NUM) return m_mot[i-2];
    return 32'd0;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic wb_xfer(input logic [31:0] a, input logic we, input logic [31:0] d,
                         output logic [31:0] q);
    @(negedge clk);
    wb_adr = a; wb_dat_w = d; wb_we = we; wb_sel = 4'hF; wb_cyc = 1'b1; wb_stb = 1'b1;
    @(posedge clk); #1;
    chk("ack_rise", {31'd0, wb_ack}, 32'd1);
    q = wb_dat_r;
    wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0;
    @(posedge clk); #1;
    chk("ack_fall", {31'd0, wb_ack}, 32'd0);
    chk("dat_hold", wb_dat_r, q);
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    logic [31:0] q;
    wb_xfer(a, 1'b1, d, q);
    model_write(a, d);
  endtask

  task automatic bus_check(input logic [31:0] a, input string tag);
    logic [31:0] q;
    wb_xfer(a, 1'b0, 32'd0, q);
    chk(tag, q, model_read(a));
  endtask

  task automatic check_all_regs();
    for (int i = 0; i < 2 + NUM; i++) bus_check(32'(i * 4), $sformatf("reg_%02h", i * 4));
  endtask

  task automatic measure(input int len);
    for (int n = 0; n < NUM; n++) begin ca[n] = 0; cb[n] = 0; end
    cab = 0;
    repeat (len) begin
      @(posedge clk); #1;
      for (int n = 0; n < NUM; n++) begin
        ca[n] += int'(mot_a[n]);
        cb[n] += int'(mot_b[n]);
        if (mot_a[n] && mot_b[n] && m_mot[n][1:0] != 2'b11) cab++;
      end
    end
  endtask

  // Any window of exactly PERIOD cycles visits every counter value once,
  // so the high count per channel is min(DUTY, PERIOD) when the channel is driven.
  task automatic check_outputs(input string tag);
    int p, len, hi, wa, wb;
    p = int'(m_period);
    len = (p == 0) ? 16 : p;
    repeat (p + 4) @(posedge clk);
    measure(len);
    for (int n = 0; n < NUM; n++) begin
      hi = (p == 0 || !m_enable[n]) ? 0 :
           ((int'(m_mot[n][31:16]) < p) ? int'(m_mot[n][31:16]) : p);
      wa = 0; wb = 0;
      case (m_mot[n][1:0])
        2'b01: wa = hi;
        2'b10: wb = hi;
        2'b11: begin wa = len; wb = len; end
        default: ;
      endcase
      chk($sformatf("%s_a%0d", tag, n), ca[n], wa);
      chk($sformatf("%s_b%0d", tag, n), cb[n], wb);
    end
    chk({tag, "_ab_nonbrake"}, cab, 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [31:0] d, q;
    int p, sel, hits;
    logic [15:0] duty;

    rst = 1'b1;
    wb_adr = '0; wb_dat_w = '0; wb_we = 1'b0; wb_cyc = 1'b0; wb_stb = 1'b0; wb_sel = 4'h0;
    m_period = 32'd1000; m_enable = 32'd0;
    for (int n = 0; n < NUM; n++) m_mot[n] = 32'd0;

    repeat (20) @(posedge clk);
    #1;
    chk("rst_ack", {31'd0, wb_ack}, 32'd0);
    chk("rst_dat", wb_dat_r, 32'd0);
    chk("rst_mot_a", 32'(mot_a), 32'd0);
    chk("rst_mot_b", 32'(mot_b), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    wb_xfer(32'h00, 1'b0, 32'd0, q); chk("rst_period", q, 32'h3E8);
    wb_xfer(32'h04, 1'b0, 32'd0, q); chk("rst_enable", q, 32'h0);
    wb_xfer(32'h08, 1'b0, 32'd0, q); chk("rst_mot0", q, 32'h0);
    chk("idle_mot_a", 32'(mot_a), 32'd0);

    // forward PWM
    bus_write(32'h00, 32'd10);
    bus_write(32'h08, 32'h0005_0001);
    bus_write(32'h04, 32'h1);
    bus_check(32'h08, "fwd_readback");
    check_outputs("fwd");

    // reverse, brake with enable off, stop
    bus_write(32'h08, 32'h0005_0002);
    check_outputs("rev");
    bus_write(32'h04, 32'h0);
    bus_write(32'h08, 32'h0005_0003);
    check_outputs("brake");
    bus_write(32'h08, 32'h0005_0000);
    check_outputs("stop");

    // duty bounds
    bus_write(32'h04, 32'h1);
    bus_write(32'h08, 32'h0000_0001);
    check_outputs("duty0");
    bus_write(32'h08, 32'h000A_0001);
    check_outputs("duty_eq_per");
    bus_write(32'h08, 32'hFFFF_0001);
    check_outputs("duty_max");
    bus_write(32'h00, 32'h0);
    check_outputs("period0");

    // held strobe: back-to-back writes, ack toggles every cycle
    @(negedge clk);
    wb_adr = 32'h08; wb_dat_w = 32'h1; wb_we = 1'b1; wb_cyc = 1'b1; wb_stb = 1'b1;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk); #1;
      chk($sformatf("held_ack%0d", i), {31'd0, wb_ack}, (i % 2 == 0) ? 32'd1 : 32'd0);
    end
    @(negedge clk);
    wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0;
    model_write(32'h08, 32'h1);
    wb_xfer(32'h08, 1'b0, 32'd0, q); chk("held_mot0", q, 32'h0000_0001);
    bus_write(32'h40, 32'hFFFF_FFFF);
    wb_xfer(32'h40, 1'b0, 32'd0, q); chk("unmapped_40", q, 32'h0);
    wb_xfer(32'h20, 1'b0, 32'd0, q); chk("unmapped_mot6", q, 32'h0);
    wb_xfer(32'h108, 1'b0, 32'd0, q); chk("alias_108", q, 32'h0000_0001);
    wb_xfer(32'h0B, 1'b0, 32'd0, q); chk("alias_0b", q, 32'h0000_0001);
    check_all_regs();

    // randomized configurations across all channels
    for (int it = 0; it < 8; it++) begin
      p = $urandom_range(1, 24);
      bus_write(32'h00, 32'(p));
      for (int n = 0; n < NUM; n++) begin
        sel = $urandom_range(0, 4);
        case (sel)
          0: duty = 16'd0;
          1: duty = 16'(p);
          2: duty = 16'hFFFF;
          3: duty = 16'($urandom_range(0, p));
          default: duty = 16'($urandom);
        endcase
        d = {duty, 8'($urandom), 6'($urandom), 2'($urandom_range(0, 3))};
`ifdef WB_MOTORES_TIMEOUT_EN
        d[15:8] = 8'd0;
`endif
        bus_write(32'(8 + 4 * n), d);
      end
      bus_write(32'h04, $urandom);
      check_all_regs();
      check_outputs($sformatf("rnd%0d", it));
    end

    // run counter: 3 full PWM periods then auto-stop
    bus_write(32'h00, 32'h0);
    for (int n = 1; n < NUM; n++) bus_write(32'(8 + 4 * n), 32'h0);
    bus_write(32'h08, 32'h0008_0301);
    bus_write(32'h04, 32'h1);
`ifdef WB_MOTORES_TIMEOUT_EN
    @(negedge clk);
    wb_adr = 32'h00; wb_dat_w = 32'd4; wb_we = 1'b1; wb_cyc = 1'b1; wb_stb = 1'b1;
    @(posedge clk); #1;
    chk("to_ack", {31'd0, wb_ack}, 32'd1);
    chk("to_pre_a", {31'd0, mot_a[0]}, 32'd0);
    wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0;
    m_period = 32'd4;
    hits = 0;
    cab = 0;
    repeat (40) begin
      @(posedge clk); #1;
      hits += int'(mot_a[0]);
      cab += int'(mot_b[0]);
    end
    chk("to_high_cycles", hits, 12);
    chk("to_b_low", cab, 0);
    m_mot[0] = 32'h0008_0000;
    bus_check(32'h08, "to_mode_cleared");
    check_outputs("to_after");
`else
    bus_write(32'h00, 32'd4);
    bus_check(32'h08, "runcnt_ignored");
    repeat (40) @(posedge clk);
    check_outputs("no_autostop");
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
